// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types for the N-port main_mem request controller.
//   req_type_t            read / write request kind
//   block_data_t          one main_mem data block
//   main_mem_block_addr_t block-granular main_mem address
//   port_id_t             requester port index, sized for MAX_MEM_PORTS
//   mem_req_entry_t       one queued request {type, addr, data}
package mem_ctrl_pkg;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef logic [31:0] block_data_t;
  typedef logic [15:0] main_mem_block_addr_t;

  // Upper bound on N_PORTS; fixes the port-id width seen by main_mem so the
  // response channel does not change shape when ports are added.
  localparam int MAX_MEM_PORTS = 8;
  localparam int PORT_ID_W     = (MAX_MEM_PORTS > 2) ? $clog2(MAX_MEM_PORTS) : 1;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef struct packed {
    req_type_t            req_type;
    main_mem_block_addr_t block_addr;
    block_data_t          block_data;
  } mem_req_entry_t;

endpackage

// File: rtl/mem_ctrl_nport_queue.sv
// mem_req_queue: per-port request FIFO of mem_req_entry_t.
//   clk, rst_aH         clock, asynchronous active-high reset (flushes)
//   enq_i, enq_data_i   push; caller only pushes when !full_o
//   deq_i               pop;  caller only pops when !empty_o
//   head_o              oldest entry (valid when !empty_o)
//   full_o, empty_o     occupancy flags
module mem_req_queue
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_aH,
  input  logic           enq_i,
  input  mem_req_entry_t enq_data_i,
  input  logic           deq_i,
  output mem_req_entry_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_req_entry_t   mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (enq_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq_i) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq_i, deq_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (enq_i) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/mem_ctrl_nport.sv
// mem_ctrl_nport: arbitrates N_PORTS queued requesters onto the single
// main_mem request channel and routes read responses back by port id.
//   clk, rst_aH                 clock, asynchronous active-high reset
//   port_req_*                  per-port valid/ready request interface
//   port_resp_valid/_block_data per-port read response (pass-through)
//   mem_req_*                   request to main_mem (no backpressure)
//   mem_resp_*                  read response from main_mem
// Build option: define MEM_CTRL_NPORT_FIXED_PRIO_EN for fixed priority
// (lowest eligible port wins); otherwise round-robin arbitration.
module mem_ctrl_nport
  import mem_ctrl_pkg::*;
#(
  parameter int N_PORTS         = 2,
  parameter int QUEUE_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst_aH,
  input  logic                 [N_PORTS-1:0]  port_req_valid,
  input  req_type_t            [N_PORTS-1:0]  port_req_type,
  input  main_mem_block_addr_t [N_PORTS-1:0]  port_req_block_addr,
  input  block_data_t          [N_PORTS-1:0]  port_req_block_data,
  output logic                 [N_PORTS-1:0]  port_req_ready,
  output logic                 [N_PORTS-1:0]  port_resp_valid,
  output block_data_t          [N_PORTS-1:0]  port_resp_block_data,
  output logic                                mem_req_valid,
  output port_id_t                            mem_req_port_id,
  output req_type_t                           mem_req_type,
  output main_mem_block_addr_t                mem_req_block_addr,
  output block_data_t                         mem_req_block_data,
  input  logic                                mem_resp_valid,
  input  port_id_t                            mem_resp_port_id,
  input  block_data_t                         mem_resp_block_data
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic           [N_PORTS-1:0] q_full, q_empty, q_enq, q_deq, elig;
  mem_req_entry_t [N_PORTS-1:0] q_in, q_head;

  logic           grant_vld;
  port_id_t       grant_id;
  mem_req_entry_t sel;

  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ok, issue_rd, retire;

  assign out_ok         = (out_cnt_q < CNT_W'(MAX_OUTSTANDING));
  assign port_req_ready = ~q_full & {N_PORTS{~rst_aH}};
  assign q_enq          = port_req_valid & port_req_ready;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign q_in[gi] = '{req_type:   port_req_type[gi],
                        block_addr: port_req_block_addr[gi],
                        block_data: port_req_block_data[gi]};

    // Writes never produce a response, so they bypass the outstanding limit.
    assign elig[gi] = !q_empty[gi] &&
                      ((q_head[gi].req_type == REQ_WRITE) || out_ok);

    assign port_resp_valid[gi]      = mem_resp_valid && !rst_aH &&
                                      (mem_resp_port_id == port_id_t'(gi));
    assign port_resp_block_data[gi] = mem_resp_block_data;

    mem_req_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk       (clk),
      .rst_aH    (rst_aH),
      .enq_i     (q_enq[gi]),
      .enq_data_i(q_in[gi]),
      .deq_i     (q_deq[gi]),
      .head_o    (q_head[gi]),
      .full_o    (q_full[gi]),
      .empty_o   (q_empty[gi])
    );
  end

`ifdef MEM_CTRL_NPORT_FIXED_PRIO_EN
  // Scan downward so the lowest eligible index is the last (winning) write.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant_vld = 1'b1;
        grant_id  = port_id_t'(i);
      end
    end
  end
`else
  port_id_t rr_ptr_q, rr_ptr_d;

  // Search order rr_ptr+1, rr_ptr+2, ... wrapping; first eligible hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (!grant_vld && elig[i] && (((int'(rr_ptr_q) + k) % N_PORTS) == i)) begin
          grant_vld = 1'b1;
          grant_id  = port_id_t'(i);
        end
      end
    end
    rr_ptr_d = grant_vld ? grant_id : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) rr_ptr_q <= port_id_t'(N_PORTS - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    q_deq = '0;
    sel   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_vld && (grant_id == port_id_t'(i))) begin
        q_deq[i] = 1'b1;
        sel      = q_head[i];
      end
    end
  end

  assign mem_req_valid      = grant_vld && !rst_aH;
  assign mem_req_port_id    = grant_id;
  assign mem_req_type       = sel.req_type;
  assign mem_req_block_addr = sel.block_addr;
  assign mem_req_block_data = sel.block_data;

  // A response with nothing outstanding (e.g. in flight across a reset) is
  // not counted, so the counter can never wrap below zero.
  always_comb begin
    issue_rd  = mem_req_valid && (sel.req_type == REQ_READ);
    retire    = mem_resp_valid && (out_cnt_q != '0);
    out_cnt_d = out_cnt_q;
    if (issue_rd && !retire)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!issue_rd && retire) out_cnt_d = out_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) out_cnt_q <= '0;
    else        out_cnt_q <= out_cnt_d;
  end

endmodule

// File: doc/mem_ctrl_nport.md
# mem_ctrl_nport

Parametrised successor to the two-port memory controller: arbitrates N requester ports (icache, dcache, future prefetcher/DMA) onto the single latency-sensitive main_mem request channel and routes read responses back by port ID. Each port has a small request queue, so a requester sees a latency-insensitive valid/ready interface. Round-robin arbitration and an outstanding-read limit protect the main_mem response path. Sits between the core's caches and main_mem in top.

## Interface
- N_PORTS, 2, number of requester ports (≥2); port 0 = icache, port 1 = dcache by convention
- QUEUE_DEPTH, 2, per-port request queue entries (power of two, ≥1)
- MAX_OUTSTANDING, 4, max reads issued to main_mem and not yet answered
- clk  in  1  clock, all state on rising edge
- rst_aH  in  1  asynchronous, active-high reset
- port_req_valid  in  [N_PORTS]  request valid per port
- port_req_type  in  req_type_t[N_PORTS]  read/write
- port_req_block_addr  in  main_mem_block_addr_t[N_PORTS]  block address
- port_req_block_data  in  block_data_t[N_PORTS]  write data
- port_req_ready  out  [N_PORTS]  queue can accept
- port_resp_valid  out  [N_PORTS]  read data valid, one cycle
- port_resp_block_data  out  block_data_t[N_PORTS]  read data
- mem_req_valid  out  1  request to main_mem
- mem_req_port_id  out  port_id_t  issuing port
- mem_req_type  out  req_type_t  read/write
- mem_req_block_addr  out  main_mem_block_addr_t  block address
- mem_req_block_data  out  block_data_t  write data
- mem_resp_valid  in  1  main_mem read response
- mem_resp_port_id  in  port_id_t  port the response belongs to
- mem_resp_block_data  in  block_data_t  read data

## Operation
- Per port: FIFO of {type, addr, data}; enqueue on port_req_valid && port_req_ready; port_req_ready = !full && !rst_aH (no full-queue bypass; a dequeue does not free a slot in the same cycle).
- Eligible port: queue non-empty and (head is write, or outstanding < MAX_OUTSTANDING).
- Arbiter: round-robin over eligible ports, search starts at rr_ptr+1 mod N_PORTS; winner's head drives mem_req_* combinationally and is dequeued at the edge; rr_ptr ← winner. No eligible port → mem_req_valid=0, rr_ptr holds.
- Outstanding counter (width $clog2(MAX_OUTSTANDING+1)): +1 on read issue, −1 on mem_resp_valid, unchanged on both in same cycle; saturation impossible by eligibility rule.
- Writes produce no response and do not touch the counter.
- Response routing: port_resp_valid[mem_resp_port_id] = mem_resp_valid; all ports' port_resp_block_data = mem_resp_block_data. Port ID ≥ N_PORTS: no port asserted, counter still decrements.
- Per-port order preserved; cross-port order is arbitration order.

## Timing
- Reset values: all queues empty, rr_ptr = N_PORTS−1 (port 0 wins first), counter 0, port_req_ready=0 while rst_aH, mem_req_valid=0, port_resp_valid=0 (gated during reset).
- Request accepted at edge t → earliest mem_req_valid in cycle t+1.
- Response: zero-cycle pass-through, mem_resp_valid in cycle t → port_resp_valid in cycle t.
- Reset asserted mid-operation: queues flushed, counter cleared immediately; in-flight main_mem responses after reset release are dropped if counter is 0 (counter must not underflow).
- One grant per cycle; sustained throughput one request per cycle across all ports.

## Configuration
- MEM_CTRL_NPORT_FIXED_PRIO_EN: defined → fixed priority, lowest eligible port index wins, rr_ptr removed. Undefined → round-robin as above (default).

## Structure
- mem_ctrl_pkg: port_id_t (width max(1,$clog2(N_PORTS)) via package-level MAX_MEM_PORTS constant), mem_req_entry_t struct {req_type_t, main_mem_block_addr_t, block_data_t}; reuses req_type_t, block_data_t, main_mem_block_addr_t from global defs.
- One sub-module: mem_req_queue (parametrised FIFO of mem_req_entry_t, full/empty, instantiated N_PORTS times).

## Test plan
- Single read on port 1 addr 0x10 at t → mem_req_valid t+1, port_id=1, type=read; mem_resp data 0xABCD with port_id=1 → port_resp_valid[1]=1 same cycle, counter back to 0.
- N_PORTS=3, all ports continuously valid reads → grants 0,1,2,0,1,2; with FIXED_PRIO_EN → port 0 every cycle until its queue empties.
- MAX_OUTSTANDING=4, five reads, no responses → four issued, fifth held; one response → fifth issues next cycle; concurrent write still issues while reads blocked.
- Fill port 0 queue (QUEUE_DEPTH=2) with mem path stalled → port_req_ready[0]=0; dequeue → ready=1 next cycle.
- Simultaneous read issue and mem_resp_valid → counter unchanged; mem_resp_port_id=5 with N_PORTS=3 → no port_resp_valid, counter decrements.
- rst_aH pulsed with 3 queued requests and 2 outstanding → queues empty, counter 0, mem_req_valid=0, port 0 granted first after release.
